gerenciador_de_ativos: RTL and testbench
========================================

# gerenciador_de_ativos

Active-node manager for the array of NUM_NA node agents (NA). Each cycle it compares a requested address against the addresses and active flags the NAs report. It then issues a one-hot, one-cycle enable to the single NA that must act: the NA already holding the address, a free NA to allocate, or the NA to be deactivated. It sits between the upstream scheduler, which drives the commands, and the NA array, which consumes habilitar_out.

## Interface
- NUM_NA, default 8: number of node agents; width of the enable vector.
- ADR_WIDTH, default 5: width of one node address.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- desativar_in  in  1  deactivate command for endereco_in; single-cycle pulse.
- atualizar_in  in  1  update/allocate command for endereco_in; single-cycle pulse.
- endereco_in  in  ADR_WIDTH  node address of the current command.
- na_endereco_in  in  ADR_WIDTH*NUM_NA  packed NA addresses; NA i occupies bits [i*ADR_WIDTH +: ADR_WIDTH].
- na_ativo_in  in  NUM_NA  bit i = 1 when NA i currently holds a valid node.
- habilitar_out  out  NUM_NA  registered enable, one-hot or all-zero.

## Operation
- Match vector: bit i of hit is 1 when na_ativo_in[i] = 1 and the NA i address slice equals endereco_in.
- Free vector: bit i of livre is 1 when na_ativo_in[i] = 0 and reservado[i] = 0.
- reservado is an internal NUM_NA-bit register of NAs allocated but not yet reported active.
- Command priority: desativar_in over atualizar_in. When both are asserted, only the deactivate is executed.
- Deactivate (desativar_in = 1):
  - If any hit bit is set, habilitar_out becomes one-hot at the lowest-index hit.
  - Otherwise habilitar_out becomes 0.
  - reservado[i] is cleared for the enabled index.
- Update (atualizar_in = 1, desativar_in = 0):
  - If any hit bit is set, habilitar_out becomes one-hot at the lowest-index hit. This refreshes the existing NA; reservado is unchanged.
  - Otherwise, if any livre bit is set, habilitar_out becomes one-hot at the lowest-index free NA, and the matching reservado bit is set.
  - Otherwise (no hit, no free NA), habilitar_out becomes 0. The request is dropped silently.
- No command: habilitar_out becomes 0.
- Reservation release: reservado[i] clears on any cycle in which na_ativo_in[i] = 1.
- Priority encoding: a fixed lowest-index-wins priority encoder, parameterized on NUM_NA. No round-robin.
- Address comparison is exact over all ADR_WIDTH bits. Address 0 is a legal address.

## Timing
- All decisions use inputs sampled at the rising edge; habilitar_out is valid from that edge.
- Latency is 1 cycle from command to enable.
- habilitar_out is high for exactly one cycle per command. Back-to-back commands give back-to-back enables.
- No handshake and no busy signal; a command is accepted on every cycle.
- Reset (rst_n = 0 at a rising edge):
  - habilitar_out = 0 and reservado = 0.
  - Reset takes priority over commands present in the same cycle.
  - Reset mid-operation discards all reservations.
- Same-cycle events:
  - A reservation set and a release for the same index in one cycle: release wins. na_ativo_in = 1 already covers the NA.
  - Consecutive atualizar_in commands with different addresses before na_ativo_in updates allocate distinct NAs, because of reservado.
- habilitar_out never has more than one bit set.

## Test plan
- Allocation after reset: rst_n pulse, na_ativo_in = 8'h00, atualizar_in with endereco_in = 5 -> habilitar_out = 8'h01 on the next cycle, then 8'h00.
- Reservation: on back-to-back cycles with na_ativo_in = 8'h00, atualizar 5 then atualizar 7 -> 8'h01 then 8'h02. Then drive na_ativo_in = 8'h03 and atualizar 9 -> 8'h04.
- Hit/refresh: na_ativo_in = 8'h05, NA2 address = 9, atualizar 9 -> 8'h04. Address 9 on inactive NA1 is ignored.
- Full array: na_ativo_in = 8'hFF, no address equal to 3, atualizar 3 -> 8'h00. The same command with NA6 holding address 3 -> 8'h40.
- Deactivate and priority: NA2 active with address 9, desativar 9 -> 8'h04. desativar 12 with no match -> 8'h00. desativar and atualizar together for address 12 with a free NA0 -> 8'h00, with no allocation.
- Reset mid-operation: allocate NA0 (8'h01), assert rst_n = 0 during the next atualizar -> 8'h00. After release, atualizar again with na_ativo_in = 0 -> 8'h01, because the reservation was cleared.

Source files
------------

// File: rtl/gerenciador_de_ativos.sv
`default_nettype none
// ============================================================================
// Module   : gerenciador_de_ativos
// Brief    : Active-node manager. Matches a requested node address against
//            the NA array and issues a registered one-hot enable to the NA
//            that holds the address, a free NA to allocate, or the NA to be
//            deactivated. Tracks allocated-but-not-yet-active NAs.
// Revision : 1.0 - initial release
// ============================================================================
module gerenciador_de_ativos #(
  parameter int NUM_NA    = 8,
  parameter int ADR_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          desativar_in,
  input  logic                          atualizar_in,
  input  logic [ADR_WIDTH-1:0]          endereco_in,
  input  logic [ADR_WIDTH*NUM_NA-1:0]   na_endereco_in,
  input  logic [NUM_NA-1:0]             na_ativo_in,
  output logic [NUM_NA-1:0]             habilitar_out
);

  // NAs handed out by an allocation that have not yet reported active
  logic [NUM_NA-1:0] r_reservado;
  logic [NUM_NA-1:0] r_habilitar;

  logic [NUM_NA-1:0] w_hit;
  logic [NUM_NA-1:0] w_livre;
  logic [NUM_NA-1:0] w_hit_oh;
  logic [NUM_NA-1:0] w_livre_oh;
  logic [NUM_NA-1:0] w_hab_next;
  logic [NUM_NA-1:0] w_res_next;

  // Isolates the lowest set bit: x & -x in two's complement
  function automatic logic [NUM_NA-1:0] f_lowest(input logic [NUM_NA-1:0] x);
    return x & ((~x) + NUM_NA'(1));
  endfunction

  // Per-NA exact address comparison, qualified by the active flag
  generate
    for (genvar i = 0; i < NUM_NA; i++) begin : g_cmp
      assign w_hit[i] = na_ativo_in[i] &&
                        (na_endereco_in[i*ADR_WIDTH +: ADR_WIDTH] == endereco_in);
    end
  endgenerate

  assign w_livre    = ~na_ativo_in & ~r_reservado;
  assign w_hit_oh   = f_lowest(w_hit);
  assign w_livre_oh = f_lowest(w_livre);

  // Command decode: deactivate beats update; update refreshes a hit or allocates
  always_comb begin
    w_hab_next = '0;
    w_res_next = r_reservado;
    if (desativar_in) begin
      w_hab_next = w_hit_oh;
      w_res_next = r_reservado & ~w_hit_oh;
    end else if (atualizar_in) begin
      if (|w_hit) begin
        w_hab_next = w_hit_oh;
      end else if (|w_livre) begin
        w_hab_next = w_livre_oh;
        w_res_next = r_reservado | w_livre_oh;
      end
    end
    // An NA reporting active no longer needs its reservation; this also
    // makes release win over a same-cycle set.
    w_res_next = w_res_next & ~na_ativo_in;
  end

  // Registered enable and reservation state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_habilitar <= '0;
      r_reservado <= '0;
    end else begin
      r_habilitar <= w_hab_next;
      r_reservado <= w_res_next;
    end
  end

  assign habilitar_out = r_habilitar;

endmodule
`default_nettype wire

// File: tb/tb_gerenciador_de_ativos.sv
`default_nettype none
// ============================================================================
// Module   : tb_gerenciador_de_ativos
// Brief    : Directed plus randomized checks of gerenciador_de_ativos against
//            a behavioural reservation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gerenciador_de_ativos;

  localparam int NUM_NA    = 8;
  localparam int ADR_WIDTH = 5;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        desativar_in;
  logic                        atualizar_in;
  logic [ADR_WIDTH-1:0]        endereco_in;
  logic [ADR_WIDTH*NUM_NA-1:0] na_endereco_in;
  logic [NUM_NA-1:0]           na_ativo_in;
  logic [NUM_NA-1:0]           habilitar_out;

  int n_vec  = 0;
  int n_fail = 0;

  // Model state: which NAs are reserved
  bit m_res [NUM_NA];

  gerenciador_de_ativos #(.NUM_NA(NUM_NA), .ADR_WIDTH(ADR_WIDTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .desativar_in   (desativar_in),
    .atualizar_in   (atualizar_in),
    .endereco_in    (endereco_in),
    .na_endereco_in (na_endereco_in),
    .na_ativo_in    (na_ativo_in),
    .habilitar_out  (habilitar_out)
  );

  always #5 clk = ~clk;

  task automatic set_na(input int idx, input logic [ADR_WIDTH-1:0] v);
    na_endereco_in[idx*ADR_WIDTH +: ADR_WIDTH] = v;
  endtask

  // Apply one cycle of stimulus, advance the model at the edge, then compare
  task automatic step(input logic r, input logic d, input logic a,
                      input logic [ADR_WIDTH-1:0] e, input logic [NUM_NA-1:0] at,
                      input string tag);
    logic [NUM_NA-1:0] exp;
    int                sel;
    @(negedge clk);
    rst_n        = r;
    desativar_in = d;
    atualizar_in = a;
    endereco_in  = e;
    na_ativo_in  = at;
    @(posedge clk);
    exp = '0;
    sel = -1;
    if (!r) begin
      for (int i = 0; i < NUM_NA; i++) m_res[i] = 1'b0;
    end else begin
      if (d || a) begin
        for (int i = 0; i < NUM_NA; i++)
          if (sel < 0 && at[i] && na_endereco_in[i*ADR_WIDTH +: ADR_WIDTH] == e) sel = i;
      end
      if (d) begin
        if (sel >= 0) m_res[sel] = 1'b0;
      end else if (a && sel < 0) begin
        for (int i = 0; i < NUM_NA; i++)
          if (sel < 0 && !at[i] && !m_res[i]) sel = i;
        if (sel >= 0) m_res[sel] = 1'b1;
      end
      if (sel >= 0) exp = NUM_NA'(1) << sel;
      for (int i = 0; i < NUM_NA; i++) if (at[i]) m_res[i] = 1'b0;
    end
    #1;
    n_vec++;
    assert (habilitar_out === exp) else begin
      n_fail++;
      $error("FAIL %s: habilitar_out=%h expected %h", tag, habilitar_out, exp);
    end
    assert ($countones(habilitar_out) <= 1) else begin
      n_fail++;
      $error("FAIL %s_onehot: habilitar_out=%h expected at most one bit", tag, habilitar_out);
    end
  endtask

  initial begin
    rst_n = 1'b0; desativar_in = 1'b0; atualizar_in = 1'b0;
    endereco_in = '0; na_ativo_in = '0;
    for (int i = 0; i < NUM_NA; i++) set_na(i, ADR_WIDTH'(20 + i));

    // Reset and first allocation
    step(0, 1, 1, 5, 8'h00, "reset");
    step(1, 0, 1, 5, 8'h00, "alloc_after_reset");
    step(1, 0, 0, 5, 8'h00, "idle_after_alloc");

    // Reservation keeps back-to-back allocations distinct
    step(0, 0, 0, 0, 8'h00, "reset2");
    set_na(0, 5); set_na(1, 7);
    step(1, 0, 1, 5, 8'h00, "res_first");
    step(1, 0, 1, 7, 8'h00, "res_second");
    step(1, 0, 1, 9, 8'h03, "res_third");

    // Hit refresh; same address on an inactive NA is ignored
    set_na(1, 9); set_na(2, 9);
    step(1, 0, 1, 9, 8'h05, "hit_refresh");

    // Full array: drop, then hit on NA6
    set_na(1, 7);
    step(1, 0, 1, 3, 8'hFF, "full_drop");
    set_na(6, 3);
    step(1, 0, 1, 3, 8'hFF, "full_hit_na6");

    // Deactivate and command priority
    step(1, 1, 0, 9, 8'h04, "desativar_hit");
    step(1, 1, 0, 12, 8'h04, "desativar_miss");
    step(1, 1, 1, 12, 8'h04, "desativar_prio");
    step(1, 0, 0, 12, 8'h00, "no_cmd");

    // Reset mid-operation discards reservation
    step(0, 0, 0, 0, 8'h00, "reset3");
    step(1, 0, 1, 5, 8'h00, "mid_alloc");
    step(0, 0, 1, 7, 8'h00, "mid_reset");
    step(1, 0, 1, 7, 8'h00, "after_mid_reset");

    // Randomized: small address space so hits and collisions are frequent
    for (int n = 0; n < 400; n++) begin
      logic r, d, a;
      for (int i = 0; i < NUM_NA; i++) set_na(i, ADR_WIDTH'($urandom_range(0, 7)));
      r = ($urandom_range(0, 39) != 0);
      d = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 1) == 0);
      step(r, d, a, ADR_WIDTH'($urandom_range(0, 7)),
           NUM_NA'($urandom_range(0, 3) == 0 ? 0 : $urandom & $urandom), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
